// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions.
//   OP_J / OP_JAL : primary opcodes for the J-type jump instructions
//   jump_req_t    : one jump-encode request (instruction PC, byte target, link flag)
//   jump_err_t    : error flags for a request; packs as {region, misaligned}
package mips_pkg;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        link;
    } jump_req_t;

    typedef struct packed {
        logic region;      // target outside the 256 MB region of pc+4
        logic misaligned;  // target not word-aligned
    } jump_err_t;

endpackage

// File: rtl/jump_check.sv
// Combinational legality check and index extraction for one jump request.
//   pc     : byte address of the jump instruction
//   target : desired byte jump target
//   err    : {region, misaligned} error flags
//   idx    : 26-bit instruction index field (target[27:2])
module jump_check
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] target,
    output jump_err_t   err,
    output logic [25:0] idx
);

    logic [31:0] pc4;
    logic        unused_pc4_lo;

    // J-type jumps resolve against the delay-slot address, so the region is
    // taken from pc+4; the add wraps modulo 2^32 (0xFFFFFFFC -> 0).
    assign pc4           = pc + 32'd4;
    assign unused_pc4_lo = ^pc4[27:0];

    assign err.misaligned = |target[1:0];
    assign err.region     = target[31:28] != pc4[31:28];
    assign idx            = target[27:2];

endmodule

// File: rtl/jump_encoder.sv
// Encodes a jump request (PC + byte target) into a MIPS j/jal instruction word.
// Two-stage valid/ready pipeline: S1 holds checked request fields, the output
// register holds the encoded word. Errored requests produce a nop (32'h0).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake
//   in_pc, in_target    : instruction byte address and desired byte target
//   in_link             : 1 = jal, 0 = j
//   out_valid/out_ready : result handshake
//   out_instr           : encoded instruction, 32'h0 on error
//   out_err             : {region mismatch, misaligned}
//   err_count           : saturating count of errored results handed off
module jump_encoder
    import mips_pkg::*;
#(
    parameter logic [5:0] OPC_J   = OP_J,
    parameter logic [5:0] OPC_JAL = OP_JAL,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_target,
    input  logic             in_link,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [1:0]       out_err,
    output logic [CNT_W-1:0] err_count
);

    jump_req_t   req;
    jump_err_t   chk_err;
    logic [25:0] chk_idx;

    logic        s1_valid;
    jump_err_t   s1_err;
    logic [25:0] s1_idx;
    logic        s1_link;

    logic        accept;
    logic        s2_load;
    logic        xfer;
    logic [31:0] s2_instr;

    assign req = '{pc: in_pc, target: in_target, link: in_link};

    jump_check u_check (
        .pc     (req.pc),
        .target (req.target),
        .err    (chk_err),
        .idx    (chk_idx)
    );

    // S1 drains into the output register whenever that register is empty or
    // being emptied this cycle; S1 can then refill in the same cycle.
    assign accept   = in_valid & in_ready;
    assign s2_load  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_load;
    assign xfer     = out_valid & out_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        s2_instr = 32'h0;
        if (s1_err == '0) begin
            s2_instr = {(s1_link ? OPC_JAL : OPC_J), s1_idx};
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: data registers are reset along with their valid bits so nothing
    // downstream ever sees X, even where valid would mask it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= '0;
            s1_idx   <= '0;
            s1_link  <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_err   <= chk_err;
            s1_idx   <= chk_idx;
            s1_link  <= req.link;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_instr <= s2_instr;
            out_err   <= s1_err;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Counts only completed hand-offs, so a stalled errored result is counted once.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (xfer && (out_err != 2'b00) && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/jump_encoder.md
Name: jump_encoder

Overview:
- Inverse of the jump-target expansion path: takes a jump instruction's PC and a byte target address, and produces the 32-bit MIPS J-type instruction word (j or jal) that reaches that target.
- Used by the instruction-memory patch/loader path and by the verification program generator.
- Two-stage valid/ready pipeline.
- Validates that the target is word-aligned and lies in the same 256 MB region as PC+4.
- Flags errors and keeps a saturating error count.

Parameters:
- OPC_J, 6'b000010, opcode emitted when in_link=0
- OPC_JAL, 6'b000011, opcode emitted when in_link=1
- CNT_W, 16, width of err_count

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept request this cycle
- in_pc  input  32  byte address of the jump instruction
- in_target  input  32  desired byte jump target
- in_link  input  1  1 = jal, 0 = j
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_instr  output  32  encoded instruction; 32'h0 (nop) on error
- out_err  output  2  bit0 = target misaligned, bit1 = region mismatch
- err_count  output  CNT_W  count of errored results handed off, saturating

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_err=0, err_count=0. Reset mid-operation discards all in-flight entries with no output.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Stage S1 (registered on accept):
  - pc4 = in_pc + 32'd4, modulo 2^32; 0xFFFFFFFC wraps to 0.
  - mis = |in_target[1:0]
  - reg_err = in_target[31:28] != pc4[31:28]
  - idx = in_target[27:2]
  - link = in_link
- Stage S2 / output register:
  - out_instr = {link ? OPC_JAL : OPC_J, idx} when mis=0 and reg_err=0; otherwise 32'h0.
  - out_err = {reg_err, mis}. Both bits may be set together.
- Advance rules:
  - s2_load = s1_valid & (~out_valid | out_ready)
  - in_ready = ~s1_valid | s2_load (combinational from out_ready)
  - S1 captures new data on accept.
  - S1 clears when s2_load happens without a new accept.
  - Simultaneous accept and s2_load in the same cycle is allowed and is required for full throughput.
- Latency: accept in cycle N gives out_valid in cycle N+2. Throughput is 1 per cycle with out_ready held high.
- Ordering: strict FIFO. Nothing is dropped or duplicated under backpressure.
- Stability: while out_valid=1 and out_ready=0, out_instr and out_err hold constant. At most 2 entries are in flight; in_ready=0 when both stages are full and out_ready=0.
- err_count:
  - Increments by 1 on each output transfer with out_err != 0.
  - Saturates at all-ones; never wraps.
  - Does not change on stalled cycles.
- No X propagation: data registers reset to 0 even though their valid bits gate them.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_J, OP_JAL (parameter defaults come from these)
  - typedef jump_req_t {pc, target, link}
  - typedef jump_err_t {region, misaligned}
- Optional leaf sub-module jump_check: combinational pc4 / mis / reg_err / idx generation, instantiated in S1.
- Pipeline control and counter stay in jump_encoder.

Test Plan:
- pc=0x00400000, target=0x00400020, link=0, out_ready=1 -> out_instr=0x08100008, out_err=0, out_valid exactly 2 cycles after accept.
- Same request with link=1 -> out_instr=0x0C100008.
- target=0x00400022 -> out_instr=0, out_err=2'b01, err_count 0->1 on transfer.
- Region boundary:
  - pc=0x0FFFFFFC, target=0x10000000 -> 0x08000000, no error (pc4 region is 1).
  - pc=0x0FFFFFF8, same target -> out_err=2'b10.
  - pc=0xFFFFFFFC, target=0x00000004 -> 0x08000001 (pc4 wraps).
- Backpressure: 4 back-to-back requests with out_ready=0 for 5 cycles.
  - in_ready falls after 2 accepts; out_instr is stable while stalled.
  - Results emerge in order once out_ready=1; no loss; full rate afterwards.
- Counter and reset:
  - Preload err_count to 0xFFFE via 0xFFFE errored transfers (or force), then send 3 errored requests -> err_count stays 0xFFFF.
  - Assert rst with 2 entries in flight -> next cycle out_valid=0, err_count=0, in_ready=1.
